// File: rtl/som_train_sequencer.sv
// som_train_sequencer: training-job scheduler for the 8x8 SOM neuron array.
// Walks every pixel of every epoch (fetch, distance, MIN-tree wait, weight
// update), shrinks the neighbourhood radius per epoch, writes the 64
// codebook entries back, then optionally labels every pixel into the
// result RAM.
// Optional feature macro: SOM_SEQ_LABEL_EN (labelling pass LFETCH..LWR).
module som_train_sequencer #(
    parameter int N_PIXELS = 65536,
    parameter int N_EPOCHS = 4,
    parameter int MIN_LAT  = 2,
    parameter int R0       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [17:0] pix_addr,
    output logic        pix_oe,
    output logic        d_update,
    output logic        w_update,
    output logic [1:0]  radius,
    output logic [3:0]  epoch,
    output logic [17:0] wb_addr,
    output logic        wb_we,
    output logic [17:0] res_addr,
    output logic        res_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DIST,
        S_WAIT,
        S_UPD,
        S_WB,
`ifdef SOM_SEQ_LABEL_EN
        S_LFETCH,
        S_LDIST,
        S_LWAIT,
        S_LWR,
`endif
        S_DONE
    } state_t;

    localparam logic [17:0] PC_LAST = 18'(N_PIXELS - 1);
    localparam logic [3:0]  EC_LAST = 4'(N_EPOCHS - 1);
    localparam logic [2:0]  WC_LAST = 3'(MIN_LAT - 1);
    localparam logic [4:0]  R0_W    = 5'(R0);

    state_t      state_q, state_d;
    logic [17:0] pc_q, pc_d;
    logic [3:0]  ec_q, ec_d;
    logic [2:0]  wc_q, wc_d;
    logic [5:0]  bc_q, bc_d;
    logic [1:0]  radius_q, radius_d;

    logic [17:0] pix_addr_q;
    logic        pix_oe_q, d_update_q, w_update_q, wb_we_q;
    logic [17:0] wb_addr_q;
    logic        busy_q, done_q;

    // Radius for the epoch about to start: R0-(ec+1), saturating at zero.
    logic [4:0] ec_inc;
    logic [1:0] radius_next_epoch;
    assign ec_inc            = {1'b0, ec_q} + 5'd1;
    assign radius_next_epoch = (R0_W > ec_inc) ? 2'(R0_W - ec_inc) : 2'd0;

    // Next-state and counter update logic for the job sequence.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ec_d     = ec_q;
        wc_d     = wc_q;
        bc_d     = bc_q;
        radius_d = radius_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_FETCH;
                    pc_d     = '0;
                    ec_d     = '0;
                    radius_d = 2'(R0);
                end
            end
            S_FETCH: state_d = S_DIST;
            S_DIST: begin
                wc_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wc_d = wc_q + 3'd1;
                if (wc_q == WC_LAST) state_d = S_UPD;
            end
            S_UPD: begin
                if (pc_q != PC_LAST) begin
                    pc_d    = pc_q + 18'd1;
                    state_d = S_FETCH;
                end else if (ec_q != EC_LAST) begin
                    pc_d     = '0;
                    ec_d     = ec_q + 4'd1;
                    radius_d = radius_next_epoch;
                    state_d  = S_FETCH;
                end else begin
                    bc_d    = '0;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                bc_d = bc_q + 6'd1;
                if (bc_q == 6'd63) begin
                    pc_d = '0;
`ifdef SOM_SEQ_LABEL_EN
                    state_d = S_LFETCH;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SOM_SEQ_LABEL_EN
            S_LFETCH: state_d = S_LDIST;
            S_LDIST: begin
                wc_d    = '0;
                state_d = S_LWAIT;
            end
            S_LWAIT: begin
                wc_d = wc_q + 3'd1;
                if (wc_q == WC_LAST) state_d = S_LWR;
            end
            S_LWR: begin
                if (pc_q != PC_LAST) begin
                    pc_d    = pc_q + 18'd1;
                    state_d = S_LFETCH;
                end else begin
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // each strobe is valid in the same cycle as the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ec_q       <= '0;
            wc_q       <= '0;
            bc_q       <= '0;
            radius_q   <= '0;
            pix_addr_q <= '0;
            pix_oe_q   <= 1'b0;
            d_update_q <= 1'b0;
            w_update_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ec_q       <= ec_d;
            wc_q       <= wc_d;
            bc_q       <= bc_d;
            radius_q   <= radius_d;
`ifdef SOM_SEQ_LABEL_EN
            pix_oe_q   <= (state_d == S_FETCH) || (state_d == S_LFETCH);
            pix_addr_q <= ((state_d == S_FETCH) || (state_d == S_LFETCH)) ? pc_d : '0;
            d_update_q <= (state_d == S_DIST) || (state_d == S_LDIST);
`else
            pix_oe_q   <= (state_d == S_FETCH);
            pix_addr_q <= (state_d == S_FETCH) ? pc_d : '0;
            d_update_q <= (state_d == S_DIST);
`endif
            w_update_q <= (state_d == S_UPD);
            wb_we_q    <= (state_d == S_WB);
            wb_addr_q  <= (state_d == S_WB) ? {12'd0, bc_d} : '0;
            busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q     <= (state_d == S_DONE);
        end
    end

`ifdef SOM_SEQ_LABEL_EN
    logic [17:0] res_addr_q;
    logic        res_we_q;

    // Result-RAM write strobe and address for the labelling pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
        end else begin
            res_we_q   <= (state_d == S_LWR);
            res_addr_q <= (state_d == S_LWR) ? pc_d : '0;
        end
    end

    assign res_we   = res_we_q;
    assign res_addr = res_addr_q;
`else
    assign res_we   = 1'b0;
    assign res_addr = '0;
`endif

    assign pix_addr = pix_addr_q;
    assign pix_oe   = pix_oe_q;
    assign d_update = d_update_q;
    assign w_update = w_update_q;
    assign radius   = radius_q;
    assign epoch    = ec_q;
    assign wb_addr  = wb_addr_q;
    assign wb_we    = wb_we_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_som_train_sequencer.sv
// Testbench for som_train_sequencer: scoreboard of expected strobes per job,
// radius/epoch schedule, start re-pulses, restart from DONE, mid-job reset,
// and a second instance with R0=0 / three epochs.
module tb_som_train_sequencer;

    localparam int NP = 4;
    localparam int NE = 2;
    localparam int ML = 2;
`ifdef SOM_SEQ_LABEL_EN
    localparam bit LAB = 1'b1;
`else
    localparam bit LAB = 1'b0;
`endif

    localparam int K_PIX = 0;
    localparam int K_DU  = 1;
    localparam int K_WU  = 2;
    localparam int K_WB  = 3;
    localparam int K_RES = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic [17:0] pix_addr, wb_addr, res_addr;
    logic        pix_oe, d_update, w_update, wb_we, res_we, busy, done;
    logic [1:0]  radius;
    logic [3:0]  epoch;

    logic [17:0] pix_addr2, wb_addr2, res_addr2;
    logic        pix_oe2, d_update2, w_update2, wb_we2, res_we2, busy2, done2;
    logic [1:0]  radius2;
    logic [3:0]  epoch2;

    som_train_sequencer #(.N_PIXELS(NP), .N_EPOCHS(NE), .MIN_LAT(ML), .R0(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_addr(pix_addr), .pix_oe(pix_oe), .d_update(d_update), .w_update(w_update),
        .radius(radius), .epoch(epoch), .wb_addr(wb_addr), .wb_we(wb_we),
        .res_addr(res_addr), .res_we(res_we), .busy(busy), .done(done)
    );

    som_train_sequencer #(.N_PIXELS(NP), .N_EPOCHS(3), .MIN_LAT(ML), .R0(0)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .pix_addr(pix_addr2), .pix_oe(pix_oe2), .d_update(d_update2), .w_update(w_update2),
        .radius(radius2), .epoch(epoch2), .wb_addr(wb_addr2), .wb_we(wb_we2),
        .res_addr(res_addr2), .res_we(res_we2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
        int addr;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  t0       = 0;
    int  done_rel = 0;
    bit  mon_en   = 1'b0;
    bit  job_on   = 1'b0;
    int  max_epoch2 = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Expected strobe sequence of one job, relative to the start cycle.
    task automatic push_job(output int d_rel);
        int t;
        t = 1;
        for (int e = 0; e < NE; e++) begin
            for (int p = 0; p < NP; p++) begin
                exp_q.push_back('{t, K_PIX, p});
                exp_q.push_back('{t + 1, K_DU, 0});
                exp_q.push_back('{t + 2 + ML, K_WU, 0});
                t += 3 + ML;
            end
        end
        for (int b = 0; b < 64; b++) exp_q.push_back('{t + b, K_WB, b});
        t += 64;
        if (LAB) begin
            for (int p = 0; p < NP; p++) begin
                exp_q.push_back('{t, K_PIX, p});
                exp_q.push_back('{t + 1, K_DU, 0});
                exp_q.push_back('{t + 2 + ML, K_RES, p});
                t += 3 + ML;
            end
        end
        d_rel = t;
    endtask

    // Per-cycle monitor: scoreboard pop on every strobe, schedule checks.
    always @(negedge clk) begin
        int rel;
        logic [4:0] s;
        if (mon_en) begin
            rel = cyc - t0;
            s = {res_we, wb_we, w_update, d_update, pix_oe};
            check_val("excl", 64'($countones(s) <= 1), 1);
            for (int k = 0; k < 5; k++) begin
                if (s[k]) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_strobe_kind", k, 64'(exp_q.size()) + 100);
                    end else begin
                        ev = exp_q.pop_front();
                        check_val("strobe_cycle", rel, ev.cyc);
                        check_val("strobe_kind", k, ev.kind);
                        case (k)
                            K_PIX: check_val("pix_addr", pix_addr, ev.addr);
                            K_WB:  check_val("wb_addr", wb_addr, ev.addr);
                            K_RES: check_val("res_addr", res_addr, ev.addr);
                            default: ;
                        endcase
                    end
                end
            end
            if (job_on && rel >= 1 && rel <= 20) begin
                check_val("radius_ep0", radius, 3);
                check_val("epoch_ep0", epoch, 0);
            end
            if (job_on && rel >= 21 && rel <= 40) begin
                check_val("radius_ep1", radius, 2);
                check_val("epoch_ep1", epoch, 1);
            end
            check_val("excl2", 64'($countones({res_we2, wb_we2, w_update2, d_update2, pix_oe2}) <= 1), 1);
            if (busy2) check_val("radius2_zero", radius2, 0);
            if (pix_oe2) check_val("pix_addr2_range", 64'(pix_addr2 < 18'(NP)), 1);
            if (wb_we2) check_val("wb_addr2_range", 64'(wb_addr2 < 18'd64), 1);
            if (res_we2) check_val("res_addr2_range", 64'(res_addr2 < 18'(NP)), 1);
            if (int'(epoch2) > max_epoch2) max_epoch2 = int'(epoch2);
        end
    end

    task automatic launch();
        start = 1'b1;
        t0 = cyc;
        push_job(done_rel);
        job_on = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to(input int last_rel, input bit repulse);
        int r;
        while ((cyc - t0) < last_rel) begin
            r = cyc - t0;
            start = repulse && (r == 7 || r == 50);
            if (r == done_rel - 1) begin
                check_val("done_before_end", done, 0);
                check_val("busy_before_end", busy, 1);
            end
            if (r == done_rel) begin
                check_val("done_at_end", done, 1);
                check_val("busy_at_end", busy, 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_a"}, {pix_addr, pix_oe, d_update, w_update, radius, epoch, wb_we, busy, done}, 0);
        check_val({tag, "_b"}, {wb_addr, res_addr, res_we}, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_busy", busy, 0);

        // Job A: start re-pulsed at cycles 7 and 50 must not disturb it.
        launch();
        run_to(done_rel + 3, 1'b1);
        check_val("queue_drained_A", exp_q.size(), 0);
        check_val("done_held", done, 1);

        // Job B: launched from DONE, aborted by reset inside WB.
        launch();
        run_to(60, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_midjob");
        rst = 1'b0;
        exp_q.delete();
        job_on = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_after_rst", {busy, done}, 0);

        // Job C: fresh start from IDLE repeats the basic timing.
        launch();
        run_to(done_rel + 3, 1'b0);
        check_val("queue_drained_C", exp_q.size(), 0);

        for (int i = 0; i < 300 && !done2; i++) @(negedge clk);
        check_val("dut2_done", done2, 1);
        check_val("dut2_max_epoch", max_epoch2, 2);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/som_train_sequencer.md
# som_train_sequencer

Top-level scheduler for the SOM processing system's 8×8 neuron array. It runs a whole training job, pixel by pixel and epoch by epoch:
- drives the image-RAM read;
- pulses the distance-update and weight-update strobes to the VEP array, with a wait for the MIN tree's latency between them;
- shrinks the neighbourhood radius each epoch;
- writes the 64 codebook entries back, then runs an optional labelling pass into the result RAM.

## Interface
- N_PIXELS, 65536: pixels per epoch, 1..262144.
- N_EPOCHS, 4: training epochs, 1..15.
- MIN_LAT, 2: cycles from `d_update` to a valid winner (MIN_1 + MIN_2 registers), 1..7.
- R0, 3: neighbourhood radius in epoch 0, 0..3.
- clk  in  1  single clock; all flops are on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a job; ignored unless the FSM is in IDLE or DONE.
- pix_addr  out  18  image RAM address (RAM_IF_A).
- pix_oe  out  1  image RAM read enable; read data is valid in the following cycle.
- d_update  out  1  VEP samples the pixel and computes distances.
- w_update  out  1  VEP applies the neighbourhood weight update.
- radius  out  2  neighbourhood radius for the USS blocks.
- epoch  out  4  current epoch index.
- wb_addr  out  18  codebook RAM address (RAM_W_A), 0..63.
- wb_we  out  1  codebook RAM write enable.
- res_addr  out  18  result RAM address (RAM_RESULT_A).
- res_we  out  1  result RAM write enable.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE; held until the next accepted `start` or `rst`.

## Operation
- States: IDLE, FETCH, DIST, WAIT, UPD, WB, LFETCH, LDIST, LWAIT, LWR, DONE.
- All outputs are registered and decoded with the state register, so each output is valid in the same cycle as its state.
- Counters:
  - pixel counter `pc` (18-bit);
  - epoch counter `ec` (4-bit);
  - wait counter `wc` (3-bit);
  - writeback counter `bc` (6-bit).
- IDLE/DONE, `start` seen → FETCH.
  - On this transition: `pc`=0, `ec`=0, `radius`=R0, `done`=0.
- FETCH:
  - `pix_oe`=1, `pix_addr`=`pc`.
  - → DIST.
- DIST:
  - `d_update`=1.
  - Pixel data is on RAM_IF_Q this cycle.
  - `wc`=0; → WAIT.
- WAIT:
  - `wc` increments each cycle.
  - Leave after MIN_LAT cycles (`wc`==MIN_LAT-1) → UPD.
- UPD:
  - `w_update`=1.
  - If `pc`≠N_PIXELS-1: `pc`++ → FETCH.
  - Else, if `ec`≠N_EPOCHS-1: `pc`=0, `ec`++, `radius`=max(R0-(`ec`+1),0) → FETCH.
  - Else: `bc`=0 → WB.
- WB:
  - `wb_we`=1, `wb_addr`=`bc`.
  - `bc` increments; after `bc`==63, `pc`=0 → LFETCH.
- LFETCH/LDIST/LWAIT mirror FETCH/DIST/WAIT. LWAIT → LWR.
- LWR:
  - `res_we`=1, `res_addr`=`pc`.
  - `w_update`=0: the codebook is frozen during labelling.
  - If `pc`≠N_PIXELS-1: `pc`++ → LFETCH. Else → DONE.
- Outputs are mutually exclusive: at most one of `pix_oe`, `d_update`, `w_update`, `wb_we`, `res_we` is high in any cycle.
- Width rules:
  - `pc` wraps at N_PIXELS-1 explicitly, never by overflow.
  - `radius` saturates at 0.
  - `epoch` = `ec`.
- Boundaries:
  - N_PIXELS=1 with N_EPOCHS=1 is legal: one pixel, then WB.
  - `start` while `busy` is ignored and does not restart the job.
  - `start` in DONE launches a new job.

## Timing
- Reset values: every output is 0, `radius`=0, `epoch`=0, state=IDLE.
- `rst` mid-job aborts within one cycle to IDLE; no partial writes are completed.
- Latency: `start` sampled at edge k puts the FSM in FETCH in cycle k+1.
- Training costs (3+MIN_LAT)·N_PIXELS·N_EPOCHS cycles.
- WB costs 64 cycles.
- Labelling costs (3+MIN_LAT)·N_PIXELS cycles.
- DONE is entered the cycle after the last LWR (or after the last WB cycle when labelling is compiled out).

## Configuration
- Macro `SOM_SEQ_LABEL_EN`.
- Defined: the labelling pass (LFETCH..LWR) is included as described above.
- Undefined:
  - After WB (`bc`==63) the FSM goes directly to DONE.
  - `res_we` and `res_addr` are tied to 0.
  - The labelling states are not synthesized.

## Test plan
All scenarios use N_PIXELS=4, N_EPOCHS=2, MIN_LAT=2, R0=3, with `SOM_SEQ_LABEL_EN` defined unless stated otherwise.
- Basic job: one `start` pulse.
  - `pix_oe` rises at cycle 1 with `pix_addr`=0, and `d_update` at cycle 2.
  - `w_update` at cycles 5, 10, …, 40 (8 pulses).
  - `wb_we` in cycles 41–104 with `wb_addr` 0..63.
  - `res_we` at cycles 109, 114, 119, 124 with `res_addr` 0..3.
  - `done`=1 from cycle 125.
- Radius schedule: `radius`=3 and `epoch`=0 in cycles 1–20; `radius`=2 and `epoch`=1 in cycles 21–40.
  - Rerun with R0=0 and N_EPOCHS=3: `radius` stays 0 throughout.
- `start` re-pulsed at cycles 7 and 50 → no effect on sequence or cycle counts.
- `rst` asserted at cycle 60 (inside WB) → cycle 61 has every output 0 and the FSM in IDLE.
  - A fresh `start` afterwards repeats the basic-job timing.
- `SOM_SEQ_LABEL_EN` undefined → `res_we` never asserts; `done`=1 from cycle 105.
- Strobe exclusivity: an assertion checks that at most one of `pix_oe`, `d_update`, `w_update`, `wb_we`, `res_we` is high in every cycle across all of the above scenarios.
